player_motion_ctrl: RTL



---
 rtl/game_pkg.sv | 23 ++
 rtl/player_motion_ctrl_if.sv | 19 +
 rtl/axis_step_sat.sv | 23 ++
 rtl/player_motion_ctrl.sv | 125 ++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared encodings for the player motion block: collision codes, FSM states,
// coordinate widths and packed-position field offsets.
package game_pkg;
   localparam int COORD_W = 10;
   localparam int POS_W   = 2 * COORD_W;
   localparam int X_LSB   = 10;
   localparam int Y_LSB   = 0;
   localparam int DELTA_W = COORD_W + 1;
   localparam int CNT_W   = 6;

   localparam logic [2:0] COL_NONE  = 3'd0;
   localparam logic [2:0] COL_UP    = 3'd1;
   localparam logic [2:0] COL_DOWN  = 3'd2;
   localparam logic [2:0] COL_LEFT  = 3'd3;
   localparam logic [2:0] COL_RIGHT = 3'd4;

   typedef enum logic [1:0] {ALIVE, KNOCKBACK, INVULN, DEAD} state_t;

   // Codes 5-7 are not real collisions and must be treated like COL_NONE.
   function automatic logic is_collision(input logic [2:0] code);
      return (code >= COL_UP) && (code <= COL_RIGHT);
   endfunction
endpackage

// File: rtl/player_motion_ctrl_if.sv
// Per-frame control inputs and player status outputs of player_motion_ctrl.
interface player_motion_ctrl_if;
   import game_pkg::*;
   logic             frame_tick;
   logic             btn_up, btn_down, btn_left, btn_right, btn_start;
   logic [2:0]       enemy_collide;
   logic [POS_W-1:0] position;
   logic [1:0]       lives;
   logic             hit, invuln, game_over;

   modport master (
      output frame_tick, btn_up, btn_down, btn_left, btn_right, btn_start, enemy_collide,
      input  position, lives, hit, invuln, game_over
   );
   modport slave (
      input  frame_tick, btn_up, btn_down, btn_left, btn_right, btn_start, enemy_collide,
      output position, lives, hit, invuln, game_over
   );
endinterface

// File: rtl/axis_step_sat.sv
// One coordinate plus a signed delta, clamped to [0, MAX] so the sprite never
// wraps or leaves the visible area.
module axis_step_sat
   import game_pkg::*;
#(
   parameter int MAX = 624
) (
   input  logic [COORD_W-1:0]        coord,
   input  logic signed [DELTA_W-1:0] delta,
   output logic [COORD_W-1:0]        result
);
   localparam logic signed [DELTA_W-1:0] MAX_S = DELTA_W'(MAX);

   logic signed [DELTA_W-1:0] sum;

   assign sum = $signed({1'b0, coord}) + delta;

   always_comb begin
      if (sum[DELTA_W-1])   result = '0;
      else if (sum > MAX_S) result = MAX_S[COORD_W-1:0];
      else                  result = sum[COORD_W-1:0];
   end
endmodule

// File: rtl/player_motion_ctrl.sv
// Per-frame player movement, knockback, invulnerability and lives tracking.
// All state advances only on frame_tick; hit is a one-cycle pulse.
module player_motion_ctrl
   import game_pkg::*;
#(
   parameter int START_X    = 320,
   parameter int START_Y    = 240,
   parameter int STEP       = 2,
   parameter int KB_STEP    = 4,
   parameter int KB_FRAMES  = 8,
   parameter int INV_FRAMES = 60,
   parameter int SCREEN_W   = 640,
   parameter int SCREEN_H   = 480,
   parameter int SPRITE     = 16,
   parameter int LIVES      = 3
) (
   input logic                 clk,
   input logic                 rst,
   player_motion_ctrl_if.slave bus
);
   localparam int X_MAX = SCREEN_W - SPRITE;
   localparam int Y_MAX = SCREEN_H - SPRITE;
   localparam logic signed [DELTA_W-1:0] STEP_D = DELTA_W'(STEP);
   localparam logic signed [DELTA_W-1:0] KB_D   = DELTA_W'(KB_STEP);

   state_t               state, state_nxt;
   logic [COORD_W-1:0]   x, y, x_sat, y_sat;
   logic [CNT_W-1:0]     cnt, cnt_nxt;
   logic [2:0]           dir, dir_nxt;
   logic [1:0]           lives, lives_nxt;
   logic                 hit, hit_nxt, restart;
   logic signed [DELTA_W-1:0] dx, dy, mv_dx, mv_dy, kb_dx, kb_dy;

   // Opposing buttons on one axis cancel out.
   assign mv_dx = (bus.btn_right && !bus.btn_left) ?  STEP_D :
                  (bus.btn_left && !bus.btn_right) ? -STEP_D : '0;
   assign mv_dy = (bus.btn_down && !bus.btn_up)    ?  STEP_D :
                  (bus.btn_up && !bus.btn_down)    ? -STEP_D : '0;

   // Push away from the enemy side that was latched on the hit.
   assign kb_dx = (dir == COL_LEFT)  ?  KB_D : (dir == COL_RIGHT) ? -KB_D : '0;
   assign kb_dy = (dir == COL_UP)    ?  KB_D : (dir == COL_DOWN)  ? -KB_D : '0;

   axis_step_sat #(.MAX(X_MAX)) u_x (.coord(x), .delta(dx), .result(x_sat));
   axis_step_sat #(.MAX(Y_MAX)) u_y (.coord(y), .delta(dy), .result(y_sat));

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      dir_nxt   = dir;
      lives_nxt = lives;
      hit_nxt   = 1'b0;
      restart   = 1'b0;
      dx        = '0;
      dy        = '0;
      case (state)
         ALIVE: begin
            if (is_collision(bus.enemy_collide)) begin
               lives_nxt = (lives != 2'd0) ? lives - 2'd1 : 2'd0;
               hit_nxt   = 1'b1;
               dir_nxt   = bus.enemy_collide;
               cnt_nxt   = CNT_W'(KB_FRAMES - 1);
               state_nxt = (lives_nxt == 2'd0) ? DEAD : KNOCKBACK;
            end else begin
               dx = mv_dx;
               dy = mv_dy;
            end
         end
         KNOCKBACK: begin
            dx = kb_dx;
            dy = kb_dy;
            if (cnt == '0) begin
               cnt_nxt   = CNT_W'(INV_FRAMES - 1);
               state_nxt = INVULN;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         INVULN: begin
            dx = mv_dx;
            dy = mv_dy;
            if (cnt == '0) state_nxt = ALIVE;
            else           cnt_nxt   = cnt - CNT_W'(1);
         end
         DEAD: begin
            if (bus.btn_start) begin
               restart   = 1'b1;
               state_nxt = ALIVE;
               lives_nxt = 2'(LIVES);
               cnt_nxt   = '0;
               dir_nxt   = COL_NONE;
            end
         end
         default: state_nxt = ALIVE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ALIVE;
         x     <= COORD_W'(START_X);
         y     <= COORD_W'(START_Y);
         lives <= 2'(LIVES);
         cnt   <= '0;
         dir   <= COL_NONE;
         hit   <= 1'b0;
      end else if (bus.frame_tick) begin
         state <= state_nxt;
         x     <= restart ? COORD_W'(START_X) : x_sat;
         y     <= restart ? COORD_W'(START_Y) : y_sat;
         lives <= lives_nxt;
         cnt   <= cnt_nxt;
         dir   <= dir_nxt;
         hit   <= hit_nxt;
      end else begin
         hit <= 1'b0;
      end
   end

   assign bus.position  = {x, y};
   assign bus.lives     = lives;
   assign bus.hit       = hit;
   assign bus.invuln    = (state == KNOCKBACK) || (state == INVULN);
   assign bus.game_over = (state == DEAD);
endmodule
